// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bundle of the read, write, claim and status signals of the
// multi-port register file.
//   master : pipeline side (ID read/claim, ALU and ID writeback)
//   slave  : register file side
//   r_addr_0/1, r_val_0/1, r_busy_0/1 : two independent read ports
//   w0_*  : ALU write port, w1_* : ID write port (wins on address clash)
//   claim_enable/claim_addr : mark a register as having a pending write
//   w_collision : sticky flag, both write ports hit one address in a cycle
interface regfile_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0] r_addr_0;
    logic [ADDR_WIDTH-1:0] r_addr_1;
    logic [DATA_WIDTH-1:0] r_val_0;
    logic [DATA_WIDTH-1:0] r_val_1;
    logic                  r_busy_0;
    logic                  r_busy_1;
    logic                  w0_enable;
    logic [ADDR_WIDTH-1:0] w0_addr;
    logic [DATA_WIDTH-1:0] w0_data;
    logic                  w1_enable;
    logic [ADDR_WIDTH-1:0] w1_addr;
    logic [DATA_WIDTH-1:0] w1_data;
    logic                  claim_enable;
    logic [ADDR_WIDTH-1:0] claim_addr;
    logic                  w_collision;

    modport master (
        output r_addr_0, r_addr_1,
        output w0_enable, w0_addr, w0_data,
        output w1_enable, w1_addr, w1_data,
        output claim_enable, claim_addr,
        input  r_val_0, r_val_1, r_busy_0, r_busy_1, w_collision
    );

    modport slave (
        input  r_addr_0, r_addr_1,
        input  w0_enable, w0_addr, w0_data,
        input  w1_enable, w1_addr, w1_data,
        input  claim_enable, claim_addr,
        output r_val_0, r_val_1, r_busy_0, r_busy_1, w_collision
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with two write ports (w0 = ALU,
// w1 = ID), two combinational read ports, optional write-to-read bypass,
// optional hardwired zero register and a per-register busy scoreboard.
//   clk   : clock, all state updates on posedge
//   rst_n : asynchronous active-low reset, also forces read outputs to 0
//   bus   : regfile_mp_if.slave carrying read/write/claim/status signals
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG   = 0,
    parameter int BYPASS     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_next;
    logic                  collision;

    // Requests that actually touch state (address 0 is dropped when hardwired)
    logic w0_ok;
    logic w1_ok;
    logic claim_ok;

    always_comb begin
        w0_ok    = bus.w0_enable    && !((ZERO_REG != 0) && (bus.w0_addr    == '0));
        w1_ok    = bus.w1_enable    && !((ZERO_REG != 0) && (bus.w1_addr    == '0));
        claim_ok = bus.claim_enable && !((ZERO_REG != 0) && (bus.claim_addr == '0));
    end

    // Writes clear busy first, then a claim re-sets it: a newly issued
    // producer takes precedence over a retiring one on the same register.
    always_comb begin
        busy_next = busy;
        if (w0_ok)    busy_next[bus.w0_addr]    = 1'b0;
        if (w1_ok)    busy_next[bus.w1_addr]    = 1'b0;
        if (claim_ok) busy_next[bus.claim_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs      <= '{default: '0};
            busy      <= '0;
            collision <= 1'b0;
        end else begin
            if (w0_ok) regs[bus.w0_addr] <= bus.w0_data;
            // Issued after w0 so ID wins when both target one register
            if (w1_ok) regs[bus.w1_addr] <= bus.w1_data;
            busy <= busy_next;
            // Collision is judged on raw enables, so it fires at address 0 too
            if (bus.w0_enable && bus.w1_enable && (bus.w0_addr == bus.w1_addr))
                collision <= 1'b1;
        end
    end

    logic [ADDR_WIDTH-1:0] r_addr [2];

    assign r_addr[0] = bus.r_addr_0;
    assign r_addr[1] = bus.r_addr_1;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [DATA_WIDTH-1:0] val;
        logic                  bsy;

        always_comb begin
            val = regs[r_addr[p]];
            bsy = busy[r_addr[p]];
            if (BYPASS != 0) begin
                if (w1_ok && (bus.w1_addr == r_addr[p])) begin
                    val = bus.w1_data;
                    bsy = 1'b0;
                end else if (w0_ok && (bus.w0_addr == r_addr[p])) begin
                    val = bus.w0_data;
                    bsy = 1'b0;
                end
            end
            if ((ZERO_REG != 0) && (r_addr[p] == '0)) begin
                val = '0;
                bsy = 1'b0;
            end
            // Reset must blank reads at once, including bypassed write data
            if (!rst_n) begin
                val = '0;
                bsy = 1'b0;
            end
        end
    end

    assign bus.r_val_0     = g_rd[0].val;
    assign bus.r_val_1     = g_rd[1].val;
    assign bus.r_busy_0    = g_rd[0].bsy;
    assign bus.r_busy_1    = g_rd[1].bsy;
    assign bus.w_collision = collision;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: drives two regfile_mp instances with identical stimulus
//   dut_a : BYPASS=1, ZERO_REG=0
//   dut_b : BYPASS=0, ZERO_REG=1
// and compares every read port and the collision flag against a behavioural
// model of the register file held in plain arrays.
`timescale 1ns/1ps
module tb_regfile_mp;
    localparam int DW = 32;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #10 clk = ~clk;

    logic [AW-1:0] r_addr_0, r_addr_1, w0_addr, w1_addr, claim_addr;
    logic [DW-1:0] w0_data, w1_data;
    logic          w0_enable, w1_enable, claim_enable;

    regfile_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
    regfile_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

    assign bus_a.r_addr_0 = r_addr_0;     assign bus_b.r_addr_0 = r_addr_0;
    assign bus_a.r_addr_1 = r_addr_1;     assign bus_b.r_addr_1 = r_addr_1;
    assign bus_a.w0_enable = w0_enable;   assign bus_b.w0_enable = w0_enable;
    assign bus_a.w0_addr = w0_addr;       assign bus_b.w0_addr = w0_addr;
    assign bus_a.w0_data = w0_data;       assign bus_b.w0_data = w0_data;
    assign bus_a.w1_enable = w1_enable;   assign bus_b.w1_enable = w1_enable;
    assign bus_a.w1_addr = w1_addr;       assign bus_b.w1_addr = w1_addr;
    assign bus_a.w1_data = w1_data;       assign bus_b.w1_data = w1_data;
    assign bus_a.claim_enable = claim_enable; assign bus_b.claim_enable = claim_enable;
    assign bus_a.claim_addr = claim_addr; assign bus_b.claim_addr = claim_addr;

    regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(0), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    // Reference model: index 0 models dut_a, index 1 models dut_b
    logic [DW-1:0] mreg [2][8];
    bit            mbusy [2][8];
    bit            mcol [2];
    int            cfg_bypass [2] = '{1, 0};
    int            cfg_zero   [2] = '{0, 1};

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit hit(input int c, input bit en, input logic [AW-1:0] wa,
                               input logic [AW-1:0] a);
        return en && (wa == a) && !(cfg_zero[c] != 0 && wa == 0);
    endfunction

    function automatic logic [DW-1:0] exp_val(input int c, input logic [AW-1:0] a);
        if (!rst_n) return '0;
        if (cfg_zero[c] != 0 && a == 0) return '0;
        if (cfg_bypass[c] != 0) begin
            if (hit(c, w1_enable, w1_addr, a)) return w1_data;
            if (hit(c, w0_enable, w0_addr, a)) return w0_data;
        end
        return mreg[c][a];
    endfunction

    function automatic logic exp_busy(input int c, input logic [AW-1:0] a);
        if (!rst_n) return 1'b0;
        if (cfg_zero[c] != 0 && a == 0) return 1'b0;
        if (cfg_bypass[c] != 0 &&
            (hit(c, w1_enable, w1_addr, a) || hit(c, w0_enable, w0_addr, a))) return 1'b0;
        return mbusy[c][a];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            mcol[c] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                mreg[c][i]  = '0;
                mbusy[c][i] = 1'b0;
            end
        end
    endtask

    task automatic model_update();
        for (int c = 0; c < 2; c++) begin
            if (w0_enable && w1_enable && w0_addr == w1_addr) mcol[c] = 1'b1;
            if (hit(c, w0_enable, w0_addr, w0_addr)) begin
                mreg[c][w0_addr] = w0_data; mbusy[c][w0_addr] = 1'b0;
            end
            if (hit(c, w1_enable, w1_addr, w1_addr)) begin
                mreg[c][w1_addr] = w1_data; mbusy[c][w1_addr] = 1'b0;
            end
            if (claim_enable && !(cfg_zero[c] != 0 && claim_addr == 0))
                mbusy[c][claim_addr] = 1'b1;
        end
    endtask

    task automatic check_all();
        chk("a.val0", bus_a.r_val_0, exp_val(0, r_addr_0));
        chk("a.val1", bus_a.r_val_1, exp_val(0, r_addr_1));
        chk("a.busy0", {31'b0, bus_a.r_busy_0}, {31'b0, exp_busy(0, r_addr_0)});
        chk("a.busy1", {31'b0, bus_a.r_busy_1}, {31'b0, exp_busy(0, r_addr_1)});
        chk("a.col", {31'b0, bus_a.w_collision}, {31'b0, mcol[0]});
        chk("b.val0", bus_b.r_val_0, exp_val(1, r_addr_0));
        chk("b.val1", bus_b.r_val_1, exp_val(1, r_addr_1));
        chk("b.busy0", {31'b0, bus_b.r_busy_0}, {31'b0, exp_busy(1, r_addr_0)});
        chk("b.busy1", {31'b0, bus_b.r_busy_1}, {31'b0, exp_busy(1, r_addr_1)});
        chk("b.col", {31'b0, bus_b.w_collision}, {31'b0, mcol[1]});
    endtask

    // Called just after a negedge: apply inputs, let them settle, compare
    task automatic drive(input logic rst,
                         input logic we0, input logic [AW-1:0] wa0, input logic [DW-1:0] wd0,
                         input logic we1, input logic [AW-1:0] wa1, input logic [DW-1:0] wd1,
                         input logic ce, input logic [AW-1:0] ca,
                         input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        rst_n = rst;
        w0_enable = we0; w0_addr = wa0; w0_data = wd0;
        w1_enable = we1; w1_addr = wa1; w1_data = wd1;
        claim_enable = ce; claim_addr = ca;
        r_addr_0 = ra0; r_addr_1 = ra1;
        if (!rst_n) model_reset();
        #1;
        check_all();
    endtask

    task automatic idle(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        drive(1'b1, 1'b0, 3'd0, '0, 1'b0, 3'd0, '0, 1'b0, 3'd0, ra0, ra1);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_update(); else model_reset();
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, '0, 1'b0, 3'd0, '0, 1'b0, 3'd0, 3'd0, 3'd5);
        tick();

        // Reset: load reg3, claim reg5, then assert reset between edges
        drive(1'b1, 1'b1, 3'd3, 32'hDEADBEEF, 1'b0, 3'd0, '0, 1'b1, 3'd5, 3'd3, 3'd5);
        tick();
        idle(3'd3, 3'd5);
        chk("pre_rst.a.r3", bus_a.r_val_0, 32'hDEADBEEF);
        chk("pre_rst.a.b5", {31'b0, bus_a.r_busy_1}, 32'd1);
        #1 rst_n = 1'b0;
        model_reset();
        for (int a = 0; a < 4; a++) begin
            r_addr_0 = 3'(a); r_addr_1 = 3'(a + 4);
            #1;
            check_all();
            chk("rst.a.val0", bus_a.r_val_0, '0);
            chk("rst.a.busy1", {31'b0, bus_a.r_busy_1}, '0);
        end
        tick();
        // Reset held across an edge with writes and a claim pending: lost
        drive(1'b0, 1'b1, 3'd3, 32'h0BADF00D, 1'b1, 3'd2, 32'h12121212, 1'b1, 3'd5, 3'd3, 3'd2);
        chk("rst.a.bypass_blank", bus_a.r_val_0, '0);
        tick();
        idle(3'd3, 3'd5);
        chk("post_rst.a.r3", bus_a.r_val_0, '0);
        chk("post_rst.a.b5", {31'b0, bus_a.r_busy_1}, '0);
        tick();

        // Dual write to distinct addresses
        drive(1'b1, 1'b1, 3'd2, 32'h11111111, 1'b1, 3'd6, 32'h22222222, 1'b0, 3'd0, 3'd2, 3'd6);
        tick();
        idle(3'd2, 3'd6);
        chk("dual.b.r2", bus_b.r_val_0, 32'h11111111);
        chk("dual.b.r6", bus_b.r_val_1, 32'h22222222);
        chk("dual.a.col", {31'b0, bus_a.w_collision}, '0);
        tick();

        // Collision: ID wins, sticky flag
        drive(1'b1, 1'b1, 3'd4, 32'hAAAA0000, 1'b1, 3'd4, 32'h0000BBBB, 1'b0, 3'd0, 3'd4, 3'd4);
        chk("col.a.bypass", bus_a.r_val_0, 32'h0000BBBB);
        tick();
        for (int i = 0; i < 10; i++) begin
            idle(3'd4, 3'd0);
            tick();
        end
        idle(3'd4, 3'd0);
        chk("col.b.r4", bus_b.r_val_0, 32'h0000BBBB);
        chk("col.a.flag", {31'b0, bus_a.w_collision}, 32'd1);
        chk("col.b.flag", {31'b0, bus_b.w_collision}, 32'd1);
        tick();

        // Bypass vs registered read
        drive(1'b1, 1'b1, 3'd1, 32'h12345678, 1'b0, 3'd0, '0, 1'b0, 3'd0, 3'd1, 3'd1);
        chk("byp.a.same", bus_a.r_val_0, 32'h12345678);
        chk("byp.b.old", bus_b.r_val_0, '0);
        tick();
        idle(3'd1, 3'd1);
        chk("byp.b.next", bus_b.r_val_0, 32'h12345678);
        tick();

        // Scoreboard on reg7
        drive(1'b1, 1'b0, 3'd0, '0, 1'b0, 3'd0, '0, 1'b1, 3'd7, 3'd7, 3'd7);
        tick();
        idle(3'd7, 3'd7);
        chk("sb.claim.a", {31'b0, bus_a.r_busy_0}, 32'd1);
        chk("sb.claim.b", {31'b0, bus_b.r_busy_0}, 32'd1);
        drive(1'b1, 1'b1, 3'd7, 32'h77777777, 1'b0, 3'd0, '0, 1'b1, 3'd7, 3'd7, 3'd7);
        tick();
        idle(3'd7, 3'd7);
        chk("sb.wc.b", {31'b0, bus_b.r_busy_0}, 32'd1);
        drive(1'b1, 1'b0, 3'd0, '0, 1'b1, 3'd7, 32'h70707070, 1'b0, 3'd0, 3'd7, 3'd7);
        chk("sb.wr.a.same", {31'b0, bus_a.r_busy_0}, '0);
        chk("sb.wr.b.same", {31'b0, bus_b.r_busy_0}, 32'd1);
        tick();
        idle(3'd7, 3'd7);
        chk("sb.wr.b.next", {31'b0, bus_b.r_busy_0}, '0);
        tick();

        // Hardwired zero register (dut_b)
        drive(1'b1, 1'b1, 3'd0, 32'hFFFFFFFF, 1'b0, 3'd0, '0, 1'b1, 3'd0, 3'd0, 3'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            idle(3'd0, 3'd0);
            chk("zero.b.val", bus_b.r_val_0, '0);
            chk("zero.b.busy", {31'b0, bus_b.r_busy_1}, '0);
            tick();
        end

        // Randomized traffic with occasional reset pulses
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(63) != 0),
                  1'($urandom_range(1)), 3'($urandom_range(7)), $urandom,
                  1'($urandom_range(1)), 3'($urandom_range(7)), $urandom,
                  1'($urandom_range(1)), 3'($urandom_range(7)),
                  3'($urandom_range(7)), 3'($urandom_range(7)));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the SCC core, succeeding the fixed 8×32 two-read/one-muxed-write file. It has two independent write ports: port 0 is the ALU stage and port 1 is the ID stage. It also provides optional write-to-read bypass, an optional hardwired zero register, and a per-register busy scoreboard so that issue logic can detect RAW hazards on pending writes. It sits between ID (operand read, claim) and ALU/ID writeback.

## Interface
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 3, address width; depth = 2**ADDR_WIDTH
- ZERO_REG, 0, 1 = register 0 always reads 0, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- r_addr_0, r_addr_1  in  ADDR_WIDTH  read port addresses
- r_val_0, r_val_1  out  DATA_WIDTH  read data (combinational)
- r_busy_0, r_busy_1  out  1  addressed register has a pending write
- w0_enable  in  1  ALU write enable
- w0_addr  in  ADDR_WIDTH  ALU write address
- w0_data  in  DATA_WIDTH  ALU write data
- w1_enable  in  1  ID write enable
- w1_addr  in  ADDR_WIDTH  ID write address
- w1_data  in  DATA_WIDTH  ID write data
- claim_enable  in  1  mark claim_addr pending
- claim_addr  in  ADDR_WIDTH  register being claimed by an issued instruction
- w_collision  out  1  sticky: both write ports hit the same address in one cycle

## Operation
- Storage: 2**ADDR_WIDTH registers of DATA_WIDTH bits, plus one busy bit per register.
- Write: at posedge, reg[wN_addr] <= wN_data for each enabled port.
  - Both ports enabled to the same address: port 1 (ID) wins.
  - Same collision sets w_collision to 1. It stays 1 until reset.
  - Both ports enabled to different addresses: both registers are written.
- Scoreboard:
  - claim_enable sets busy[claim_addr] at posedge.
  - Any enabled write clears busy[wN_addr].
  - Claim and write to the same address in the same cycle: claim wins, busy = 1 (a new producer was issued).
  - A claim of an already-busy register keeps it busy; there is no counting.
- Read, BYPASS=1:
  - If an enabled write port targets r_addr_x this cycle, r_val_x = the winning write data and r_busy_x = 0.
  - Otherwise r_val_x = reg[r_addr_x] and r_busy_x = busy[r_addr_x].
- Read, BYPASS=0: r_val_x = reg[r_addr_x] and r_busy_x = busy[r_addr_x]. New data is visible the cycle after the write.
- ZERO_REG=1:
  - Writes to address 0 are discarded.
  - Claims of address 0 are discarded.
  - Reads of address 0 return 0 with busy 0.
  - Collisions at address 0 still set w_collision.
- Both read ports are independent. They may address the same register.

## Timing
- Reset (rst_n low, takes effect immediately, independent of clk):
  - All registers = 0, all busy = 0, w_collision = 0.
  - r_val_x = 0 and r_busy_x = 0 for every address.
- Reset asserted mid-write or mid-claim: the posedge update is lost and state stays cleared. First update occurs on the first posedge with rst_n high.
- Read latency: 0 cycles (combinational from address, register state and, if BYPASS, write inputs).
- Write latency: 1 cycle to storage; 0 cycles to reads when BYPASS=1.
- Scoreboard latency: busy visible the cycle after claim; cleared the cycle after write (same cycle via bypass when BYPASS=1).
- No handshake: enables are single-cycle qualifiers, and every enabled request is accepted.

## Test plan
- Reset: load reg3 = 0xDEADBEEF, claim reg5, then pulse rst_n low between edges. Required: r_val of all addresses reads 0 immediately; r_busy = 0; w_collision = 0.
- Dual write: w0 = (addr 2, 0x11111111) and w1 = (addr 6, 0x22222222) in one cycle. Required next cycle: reg2 = 0x11111111, reg6 = 0x22222222, w_collision = 0.
- Collision: w0 = (addr 4, 0xAAAA0000) and w1 = (addr 4, 0x0000BBBB). Required: reg4 = 0x0000BBBB; w_collision = 1 and still 1 ten cycles later.
- Bypass:
  - BYPASS=1, r_addr_0 = 1, w0 = (1, 0x12345678). Required: r_val_0 = 0x12345678 in the same cycle.
  - BYPASS=0, same stimulus. Required: old value in the same cycle, new value next cycle.
- Scoreboard:
  - Claim reg7. Required: r_busy = 1 next cycle.
  - Write reg7 and claim reg7 in the same cycle. Required: busy stays 1.
  - Write reg7 alone. Required: busy = 0 next cycle (0 same cycle with BYPASS=1).
- ZERO_REG=1: write 0xFFFFFFFF to addr 0 and claim addr 0. Required: r_val = 0 and r_busy = 0 for addr 0 on every subsequent cycle.
